// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and constants for the USB link supervisor
// Purpose: state encoding (also exported on o_state_dbg) and the retry counter width.
// Ports: none (package).
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAKE_LOW   = 3'd1,
    WAIT_READY = 3'd2,
    LINK_UP    = 3'd3,
    RETRY      = 3'd4,
    FAULT      = 3'd5
  } state_t;

  localparam int RETRY_W = 4;

endpackage

// File: rtl/usb_lock_filter.sv
// rtl/usb_lock_filter.sv - debounces loss of the USB clock lock
// Purpose: o_lock_good drops only once LOCK_FILTER consecutive low samples of
//          i_usb_clk_lock have been seen (the current sample included).
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_usb_clk_lock raw PLL/DCM lock
//   o_lock_good    filtered lock status
module usb_lock_filter #(
  parameter int LOCK_FILTER = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_usb_clk_lock,
  output logic o_lock_good
);

  localparam int CNT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILTER - 1);

  // Number of earlier consecutive low samples, saturating at LOCK_FILTER-1.
  logic [CNT_W-1:0] r_low_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_low_cnt <= '0;
    end else if (i_usb_clk_lock) begin
      r_low_cnt <= '0;
    end else if (r_low_cnt != CNT_LAST) begin
      r_low_cnt <= r_low_cnt + CNT_W'(1);
    end
  end

  // Current low sample plus LOCK_FILTER-1 earlier lows means lock is lost now,
  // so the supervisor reacts on the same edge as the final low sample.
  assign o_lock_good = i_usb_clk_lock || (r_low_cnt != CNT_LAST);

endmodule

// File: rtl/usb_link_supervisor.sv
// rtl/usb_link_supervisor.sv - USB bring-up handshake initiator with retry and fault latch
// Purpose: drives o_wakeup into the USB init sequencer, declares the link up when
//          n_ready is low with good clock lock, re-wakes on timeout or lock loss,
//          and latches a fault after MAX_RETRIES consecutive failed retries.
// Optional feature: define USB_LINK_SUP_LOCK_FILTER_EN to debounce lock loss over
//          LOCK_FILTER samples; otherwise a single low lock sample is lock loss.
// Ports:
//   i_clk, i_rst       system clock, synchronous active-high reset
//   i_enable           level; 1 = bring up and hold the link
//   i_clear_fault      single-cycle pulse that leaves FAULT
//   i_usb_clk_lock     USB clock lock
//   i_n_ready          init sequencer ready, active low
//   o_wakeup           0 holds the init sequencer in its wake count
//   o_link_up          1 while in LINK_UP
//   o_fault            1 while in FAULT
//   o_retry_count      consecutive failed attempts
//   o_state_dbg        current state encoding
module usb_link_supervisor
  import usb_pkg::*;
#(
  parameter int WAKE_LOW_CYCLES = 16,
  parameter int READY_TIMEOUT   = 2**27,
  parameter int MAX_RETRIES     = 3,
  parameter int LOCK_FILTER     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_clear_fault,
  input  logic               i_usb_clk_lock,
  input  logic               i_n_ready,
  output logic               o_wakeup,
  output logic               o_link_up,
  output logic               o_fault,
  output logic [RETRY_W-1:0] o_retry_count,
  output logic [2:0]         o_state_dbg
);

  localparam int TIMER_MAX = (WAKE_LOW_CYCLES > READY_TIMEOUT) ? WAKE_LOW_CYCLES : READY_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX);
  localparam logic [TIMER_W-1:0] WAKE_LAST  = TIMER_W'(WAKE_LOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] READY_LAST = TIMER_W'(READY_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  logic w_lock_good;

`ifdef USB_LINK_SUP_LOCK_FILTER_EN
  usb_lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_filter (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_usb_clk_lock (i_usb_clk_lock),
    .o_lock_good    (w_lock_good)
  );
`else
  assign w_lock_good = i_usb_clk_lock;
  // LOCK_FILTER only shapes the filtered build.
  if (LOCK_FILTER < 1) begin : g_lock_filter_unused
  end
`endif

  state_t               r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [RETRY_W-1:0]   r_retry;

  state_t               w_next_state;
  logic [RETRY_W-1:0]   w_next_retry;

  always_comb begin
    w_next_state = r_state;
    w_next_retry = r_retry;
    if (r_state != FAULT && !i_enable) begin
      w_next_state = IDLE;
      w_next_retry = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = WAKE_LOW;
        end
        WAKE_LOW: begin
          if (r_timer == WAKE_LAST) w_next_state = WAIT_READY;
        end
        WAIT_READY: begin
          // A ready indication on the timeout cycle still wins.
          if (!i_n_ready && w_lock_good) begin
            w_next_state = LINK_UP;
            w_next_retry = '0;
          end else if (r_timer == READY_LAST) begin
            w_next_state = RETRY;
          end
        end
        LINK_UP: begin
          if (!w_lock_good || i_n_ready) w_next_state = RETRY;
        end
        RETRY: begin
          if (r_retry == RETRY_MAX) begin
            w_next_state = FAULT;
          end else begin
            w_next_state = WAKE_LOW;
            w_next_retry = r_retry + RETRY_W'(1);
          end
        end
        FAULT: begin
          if (i_clear_fault) begin
            w_next_state = IDLE;
            w_next_retry = '0;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_retry = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_retry     <= '0;
      o_wakeup    <= 1'b0;
      o_link_up   <= 1'b0;
      o_fault     <= 1'b0;
      o_state_dbg <= IDLE;
    end else begin
      r_state <= w_next_state;
      r_retry <= w_next_retry;
      // Timer restarts on every state entry and only runs in the timed states,
      // where the exit condition is reached before it could wrap.
      if (w_next_state != r_state || !(r_state == WAKE_LOW || r_state == WAIT_READY)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TIMER_W'(1);
      end
      o_wakeup    <= (w_next_state == WAIT_READY) || (w_next_state == LINK_UP);
      o_link_up   <= (w_next_state == LINK_UP);
      o_fault     <= (w_next_state == FAULT);
      o_state_dbg <= w_next_state;
    end
  end

  assign o_retry_count = r_retry;

endmodule
